// File: rtl/ecppll_seq_pkg.sv
// ecppll_seq_pkg
//   Shared definitions for the ECP5 PLL reset/lock sequencer:
//   - seq_state_e : sequencer states
//   - RETRY_W     : width of the saturating retry counter
//   - DEF_*       : default timing for the 25 MHz board oscillator
//   - max3()      : helper used to size the shared state counter
package ecppll_seq_pkg;

  typedef enum logic [2:0] {
    POR_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 8;

  // 25 MHz defaults: 10 ms lock timeout, ~41 us lock-stable window
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 250000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_MAX_RETRIES    = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit
//   Multi-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk - destination clock
//     clr - synchronous clear, forces every stage to 0
//     d   - asynchronous input
//     q   - synchronized output, STAGES cycles of latency
module sync_bit
  import ecppll_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (clr) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ecppll_reset_sequencer.sv
// ecppll_reset_sequencer
//   Drives the ECP5 PLL reset, watches its lock output and releases the SoC
//   reset once lock has been continuously stable. Runs on the free-running
//   board oscillator so it keeps sequencing while the PLL is unlocked.
//   Lock timeouts and lock loss trigger a fresh PLL reset pulse.
//
//   Optional: define ECPPLL_RETRY_LIMIT_EN to stop in FAIL (PLL held in reset)
//   once MAX_RETRIES lock timeouts have accumulated.
//
//   Ports:
//     input_clk     - 25 MHz oscillator, the only clock
//     reset         - synchronous active-high reset
//     locked        - PLL lock, asynchronous
//     ext_reset_req - synchronous level request to restart the sequence
//     pll_reset     - to PLL reset (1 = PLL held in reset)
//     soc_reset     - SoC reset request, active-high, input_clk domain
//     ready         - 1 only while running with a stable lock
//     retry_count   - saturating count of lock-timeout retries
//     lock_lost     - sticky: lock dropped while running
//     fail          - retry limit reached (always 0 without the option)
module ecppll_reset_sequencer
  import ecppll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic               input_clk,
  input  logic               reset,
  input  logic               locked,
  input  logic               ext_reset_req,
  output logic               pll_reset,
  output logic               soc_reset,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic               lock_lost,
  output logic               fail
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
      SYNC_STAGES < 2 || MAX_RETRIES < 1) begin : g_param_chk
    $error("ecppll_reset_sequencer: parameter out of range");
  end

  seq_state_e         state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               locked_s;
  logic               retry_inc;
  logic               lost_set;
  logic               cnt_clr;
  logic               cnt_run;
  logic               pll_rst_nx;
  logic [RETRY_W-1:0] retry_sat;

  // Lock history is discarded while the PLL is held in reset: its lock
  // output means nothing then, so every attempt starts from locked_s=0.
  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (input_clk),
    .clr (reset | pll_reset),
    .d   (locked),
    .q   (locked_s)
  );

  assign retry_sat = (retry_count == '1) ? retry_count : retry_count + 1'b1;

  always_comb begin
    state_nx  = state;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    unique case (state)
      POR_HOLD:  if (cnt == POR_LAST) state_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        // lock seen in the timeout cycle wins over the retry
        if (locked_s) state_nx = STABLE;
        else if (cnt == WAIT_LAST) begin
          retry_inc = 1'b1;
          state_nx  = POR_HOLD;
`ifdef ECPPLL_RETRY_LIMIT_EN
          if (int'(retry_sat) >= MAX_RETRIES) state_nx = FAIL;
`endif
        end
      end
      STABLE: begin
        if (!locked_s)                state_nx = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nx = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_nx = POR_HOLD;
          lost_set = 1'b1;
        end
      end
`ifdef ECPPLL_RETRY_LIMIT_EN
      FAIL: state_nx = FAIL;
`endif
      default: state_nx = POR_HOLD;
    endcase
    // External restart overrides lock loss and timeout bookkeeping
    if (ext_reset_req) begin
      state_nx  = POR_HOLD;
      retry_inc = 1'b0;
      lost_set  = 1'b0;
    end
  end

  assign cnt_clr = ext_reset_req || (state_nx != state);
  assign cnt_run = (state == POR_HOLD) || (state == WAIT_LOCK) || (state == STABLE);

`ifdef ECPPLL_RETRY_LIMIT_EN
  assign pll_rst_nx = (state_nx == POR_HOLD) || (state_nx == FAIL);
`else
  assign pll_rst_nx = (state_nx == POR_HOLD);
`endif

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge input_clk) begin
    if (reset) begin
      state       <= POR_HOLD;
      cnt         <= '0;
      pll_reset   <= 1'b1;
      soc_reset   <= 1'b1;
      ready       <= 1'b0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state     <= state_nx;
      pll_reset <= pll_rst_nx;
      soc_reset <= (state_nx != RUN);
      ready     <= (state_nx == RUN);
      if (cnt_clr)      cnt <= '0;
      else if (cnt_run) cnt <= cnt + 1'b1;
      if (lost_set)     lock_lost <= 1'b1;
`ifdef ECPPLL_RETRY_LIMIT_EN
      if (ext_reset_req)  retry_count <= '0;
      else if (retry_inc) retry_count <= retry_sat;
      fail <= (state_nx == FAIL);
`else
      if (retry_inc) retry_count <= retry_sat;
      fail <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/ecppll_reset_sequencer.md
Name: ecppll_reset_sequencer

Overview:
- Reset and lock sequencer that sits directly upstream of the ECP5 PLL wrapper.
- Drives the PLL's `reset` input and monitors its `locked` output.
- Releases a SoC reset request only after lock has been stable for a programmable time.
- Runs on the free-running 25 MHz board oscillator (`input_clk`), so it keeps working while the PLL is unlocked; it retries PLL reset on lock timeout and on lock loss.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_reset` is held high per reset attempt (min 1).
- LOCK_TIMEOUT, 250000: cycles to wait for lock before retrying (10 ms at 25 MHz).
- STABLE_CYCLES, 1024: cycles `locked` must stay high continuously before release.
- SYNC_STAGES, 2: flip-flop depth of the `locked` synchronizer (min 2).
- MAX_RETRIES, 4: failed attempts before FAIL; used only with the optional feature.

Ports:
- input_clk, in, 1: 25 MHz oscillator clock; the only clock.
- reset, in, 1: synchronous active-high reset.
- locked, in, 1: PLL lock, asynchronous to input_clk.
- ext_reset_req, in, 1: synchronous level request to restart the sequence (debounced button or debugger).
- pll_reset, out, 1: to PLL `reset` (1 = PLL in reset).
- soc_reset, out, 1: SoC reset request, active-high, input_clk domain; the consumer re-synchronizes it into soc_clk.
- ready, out, 1: 1 only in RUN.
- retry_count, out, 8: saturating count of lock-timeout retries.
- lock_lost, out, 1: sticky; lock dropped while in RUN.
- fail, out, 1: retry limit reached; constant 0 without the optional feature.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named `input_clk` and `reset`.
- Outputs: all registered.
- Reset values: state=POR_HOLD, counter=0, pll_reset=1, soc_reset=1, ready=0, retry_count=0, lock_lost=0, fail=0, synchronizer flops=0.
- Lock synchronizer: `locked` passes through SYNC_STAGES flops to give locked_s, SYNC_STAGES cycles of latency. Only locked_s is used.
- Counter: one shared counter, width $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, plus 1. It is cleared on every state change.
- State POR_HOLD: pll_reset=1, soc_reset=1, ready=0. After exactly PLL_RST_CYCLES cycles in the state, go to WAIT_LOCK.
- State WAIT_LOCK: pll_reset=0, soc_reset=1.
  - locked_s=1 → STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0 → POR_HOLD, and retry_count increments, saturating at 255.
  - locked_s=1 in the timeout cycle → STABLE takes priority and no retry is counted.
- State STABLE: pll_reset=0, soc_reset=1.
  - locked_s=0 → WAIT_LOCK with the timeout restarted; this is not a retry.
  - STABLE_CYCLES consecutive cycles with locked_s=1 → RUN.
- State RUN: soc_reset=0, ready=1.
  - locked_s=0 → POR_HOLD and lock_lost←1.
  - soc_reset and ready change on the clock edge at which locked_s=0 is sampled, so they are seen one cycle after locked_s falls.
- Latency from locked_s rising (after POR_HOLD) to ready=1: STABLE_CYCLES+1 cycles.
- ext_reset_req=1 in any state (including FAIL):
  - Next state is POR_HOLD and the counter is cleared.
  - retry_count and lock_lost are kept, and no retry is counted.
  - fail is cleared.
  - Held high, it keeps the block in POR_HOLD.
- Priority: reset > ext_reset_req > lock loss / timeout > normal progression. If a lock drop in RUN coincides with ext_reset_req, the ext request wins and lock_lost is not set.
- lock_lost clears only on reset.
- Glitch on locked shorter than one sample: may be missed. A glitch captured by the synchronizer is treated as a real drop.

Optional Feature:
- Macro: ECPPLL_RETRY_LIMIT_EN.
- Defined:
  - A timeout that brings retry_count to MAX_RETRIES goes to FAIL instead of POR_HOLD.
  - FAIL: pll_reset=1, soc_reset=1, ready=0, fail=1.
  - FAIL is left only via reset or ext_reset_req. ext_reset_req also clears retry_count to 0.
- Undefined:
  - Retries continue indefinitely, FAIL is absent, and fail is tied to 0.
  - ext_reset_req does not clear retry_count.

Decomposition:
- Package ecppll_seq_pkg: state enum (POR_HOLD, WAIT_LOCK, STABLE, RUN, FAIL), the retry_count width constant (8), and a default-timing localparam set for 25 MHz.
- Sub-module: `sync_bit`, a parameterized SYNC_STAGES bit synchronizer for `locked`, reusable elsewhere in the SoC.
- The FSM and counter stay in the top module.

Test Plan:
- Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYNC_STAGES=2, MAX_RETRIES=2.
- 1. Release reset with `locked` tied to 1 → pll_reset high for exactly 4 cycles; ready rises 2+8+1 cycles after pll_reset falls; soc_reset=0 from then on.
- 2. `locked`=0 forever → POR_HOLD/WAIT_LOCK cycle repeats with a period of 4+20 cycles, and retry_count increments once per period. With ECPPLL_RETRY_LIMIT_EN: fail=1 after the 2nd timeout and pll_reset is held at 1.
- 3. Lock, then drop `locked` for 3 cycles in STABLE at count 5 → WAIT_LOCK; retry_count unchanged; after relock, ready comes a full 8+1 cycles after locked_s rises.
- 4. In RUN, drop `locked` for 1 full cycle → lock_lost=1; soc_reset=1 one cycle after locked_s falls; a new 4-cycle pll_reset pulse follows; lock_lost stays 1 after recovery.
- 5. Assert ext_reset_req in RUN together with a `locked` drop → POR_HOLD, lock_lost stays 0. In FAIL, ext_reset_req → POR_HOLD, fail=0, retry_count=0.
- 6. Assert reset for 1 cycle mid-WAIT_LOCK → all outputs return to their reset values on the next edge, including retry_count=0.
